// File: rtl/turbo_encoder_stream.sv
// Flow-controlled LTE turbo encoder: two RSC constituent encoders, registered output stage.
// Trellis termination (4 tail beats per block) is built only when TURBO_ENC_TAIL_EN is defined.
module turbo_encoder_stream #(
    parameter int MAX_LEN = 6144,
    parameter int MIN_LEN = 40,
    parameter int LEN_W   = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ck,
    input  logic             ckp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             xk,
    output logic             zk,
    output logic             zkp,
    output logic             out_tail,
    output logic             out_last,
    output logic             busy,
    output logic             len_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ENC  = 2'd1;
`ifdef TURBO_ENC_TAIL_EN
    localparam logic [1:0] ST_TAIL = 2'd2;
`endif
    localparam logic [LEN_W-1:0] MIN_K = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_K = LEN_W'(MAX_LEN);

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [2:0]       r_e1;       // {s1, s2, s3}, s1 newest
    logic [2:0]       r_e2;
    logic             r_out_valid;
    logic             r_xk;
    logic             r_zk;
    logic             r_zkp;
    logic             r_last;
    logic             r_len_err;

    logic       w_f1, w_f2, w_z1, w_z2;
    logic [2:0] w_e1_next, w_e2_next;
    logic       w_slot_free, w_accept, w_fire, w_last_bit, w_len_ok;

    assign w_f1      = ck ^ r_e1[1] ^ r_e1[0];
    assign w_z1      = w_f1 ^ r_e1[2] ^ r_e1[0];
    assign w_e1_next = {w_f1, r_e1[2], r_e1[1]};
    assign w_f2      = ckp ^ r_e2[1] ^ r_e2[0];
    assign w_z2      = w_f2 ^ r_e2[2] ^ r_e2[0];
    assign w_e2_next = {w_f2, r_e2[2], r_e2[1]};

    assign w_slot_free = !r_out_valid | out_ready;
    assign w_accept    = r_out_valid & out_ready;
    assign w_last_bit  = (r_cnt == r_len - LEN_W'(1));
    assign w_len_ok    = (length >= MIN_K) && (length <= MAX_K);
    // The count guard stops input after K bits while the final data beat drains.
    assign in_ready    = (r_state == ST_ENC) && w_slot_free && (r_cnt != r_len);
    assign w_fire      = in_valid & in_ready;

`ifdef TURBO_ENC_TAIL_EN
    logic [11:0] r_tail_bits;     // beat k occupies bits [3k+2:3k] as {zkp, zk, xk}
    logic [1:0]  r_tbeat;
    logic        r_tail;
    logic [2:0]  w_tail_beat;

    // Termination of state (a,b,c): bits [5:0] = z2, x2, z1, x1, z0, x0.
    function automatic logic [5:0] term_bits(input logic [2:0] s);
        return {s[2], s[2], s[1], s[2] ^ s[1], s[2] ^ s[0], s[1] ^ s[0]};
    endfunction

    always_comb begin
        w_tail_beat = r_tail_bits[2:0];
        case (r_tbeat)
            2'd0: w_tail_beat = r_tail_bits[2:0];
            2'd1: w_tail_beat = r_tail_bits[5:3];
            2'd2: w_tail_beat = r_tail_bits[8:6];
            2'd3: w_tail_beat = r_tail_bits[11:9];
            default: w_tail_beat = r_tail_bits[2:0];
        endcase
    end

    assign out_tail = r_tail;
`else
    assign out_tail = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_e1        <= '0;
            r_e2        <= '0;
            r_out_valid <= 1'b0;
            r_xk        <= 1'b0;
            r_zk        <= 1'b0;
            r_zkp       <= 1'b0;
            r_last      <= 1'b0;
            r_len_err   <= 1'b0;
`ifdef TURBO_ENC_TAIL_EN
            r_tail_bits <= '0;
            r_tbeat     <= '0;
            r_tail      <= 1'b0;
`endif
        end else begin
            r_len_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_len   <= length;
                            r_cnt   <= '0;
                            r_e1    <= '0;
                            r_e2    <= '0;
                            r_state <= ST_ENC;
                        end else begin
                            r_len_err <= 1'b1;
                        end
                    end
                end
                ST_ENC: begin
                    if (w_fire) begin
                        r_out_valid <= 1'b1;
                        r_xk        <= ck;
                        r_zk        <= w_z1;
                        r_zkp       <= w_z2;
                        r_e1        <= w_e1_next;
                        r_e2        <= w_e2_next;
                        r_cnt       <= r_cnt + LEN_W'(1);
`ifdef TURBO_ENC_TAIL_EN
                        r_last      <= 1'b0;
                        r_tail      <= 1'b0;
                        if (w_last_bit) begin
                            r_tail_bits <= {term_bits(w_e2_next), term_bits(w_e1_next)};
                            r_tbeat     <= '0;
                            r_state     <= ST_TAIL;
                        end
`else
                        r_last      <= w_last_bit;
`endif
                    end else if (w_accept) begin
                        r_out_valid <= 1'b0;
                        r_last      <= 1'b0;
                        if (r_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
`ifdef TURBO_ENC_TAIL_EN
                ST_TAIL: begin
                    if (w_slot_free) begin
                        if (r_out_valid && r_last) begin
                            r_out_valid <= 1'b0;
                            r_last      <= 1'b0;
                            r_tail      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_xk        <= w_tail_beat[0];
                            r_zk        <= w_tail_beat[1];
                            r_zkp       <= w_tail_beat[2];
                            r_tail      <= 1'b1;
                            r_last      <= (r_tbeat == 2'd3);
                            r_tbeat     <= r_tbeat + 2'd1;
                        end
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign xk        = r_xk;
    assign zk        = r_zk;
    assign zkp       = r_zkp;
    assign out_last  = r_last;
    assign busy      = (r_state != ST_IDLE);
    assign len_err   = r_len_err;

endmodule

// File: tb/tb_turbo_encoder_stream.sv
// Scoreboard bench for turbo_encoder_stream; expected beats come from a bit-serial RSC model.
// Tail expectations follow TURBO_ENC_TAIL_EN the same way the design does.
module tb_turbo_encoder_stream;

`ifdef TURBO_ENC_TAIL_EN
    localparam int TAILN = 4;
`else
    localparam int TAILN = 0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [12:0] length;
    logic        in_valid;
    logic        in_ready;
    logic        ck;
    logic        ckp;
    logic        out_valid;
    logic        out_ready;
    logic        xk, zk, zkp, out_tail, out_last, busy, len_err;

    turbo_encoder_stream #(.MAX_LEN(6144), .MIN_LEN(40), .LEN_W(13)) dut (
        .clk(clk), .rst(rst), .start(start), .length(length),
        .in_valid(in_valid), .in_ready(in_ready), .ck(ck), .ckp(ckp),
        .out_valid(out_valid), .out_ready(out_ready),
        .xk(xk), .zk(zk), .zkp(zkp), .out_tail(out_tail), .out_last(out_last),
        .busy(busy), .len_err(len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [4:0] sb[$];          // {xk, zk, zkp, tail, last}
    int         beats_seen;
    logic [2:0] first_beat;
    logic       bp_mode;
    logic       ck_v [40];
    logic       ckp_v[40];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // s = {s1, s2, s3}
    task automatic rsc(input logic u, input logic [2:0] s, output logic z, output logic [2:0] ns);
        logic f;
        f  = u ^ s[1] ^ s[0];
        z  = f ^ s[2] ^ s[0];
        ns = {f, s[2], s[1]};
    endtask

    // Drive the encoder to zero by feeding back its own feedback; t = {z2,x2,z1,x1,z0,x0}.
    task automatic terminate(input logic [2:0] s_in, output logic [5:0] t);
        logic [2:0] s, ns;
        logic u, z;
        s = s_in;
        t = '0;
        for (int k = 0; k < 3; k++) begin
            u = s[1] ^ s[0];
            rsc(u, s, z, ns);
            t[2*k]   = u;
            t[2*k+1] = z;
            s = ns;
        end
    endtask

    task automatic monitor();
        logic [4:0] obs;
        logic [4:0] hold_val;
        logic       hold_pend;
        hold_pend = 1'b0;
        hold_val  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
            end else begin
                obs = {xk, zk, zkp, out_tail, out_last};
                if (hold_pend) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'(obs), 32'(hold_val));
                end
                hold_pend = 1'b0;
                if (out_valid && out_ready) begin
                    check("beat_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        check($sformatf("beat%0d", beats_seen), 32'(obs), 32'(sb.pop_front()));
                        if (beats_seen == 0) first_beat = obs[4:2];
                        beats_seen++;
                    end
                end else if (out_valid) begin
                    hold_pend = 1'b1;
                    hold_val  = obs;
                end
            end
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    // Starts a block of length K and feeds nfeed bits; waits for completion when nfeed == K.
    task automatic run_block(input string name, input int K, input int nfeed);
        logic [2:0] s1, s2, ns;
        logic       z1, z2, b, bp;
        logic [5:0] t1, t2;
        int         cyc;
        s1 = '0;
        s2 = '0;
        beats_seen = 0;
        @(posedge clk); #1;
        start  = 1'b1;
        length = 13'(K);
        @(posedge clk); #1;
        start  = 1'b0;
        check({name, "_busy_rise"}, 32'(busy), 32'd1);
        for (int i = 0; i < nfeed; i++) begin
            b  = (i < 40) ? ck_v[i]  : 1'b0;
            bp = (i < 40) ? ckp_v[i] : 1'b0;
            rsc(b, s1, z1, ns);  s1 = ns;
            rsc(bp, s2, z2, ns); s2 = ns;
            sb.push_back({b, z1, z2, 1'b0, (TAILN == 0) && (i == K - 1)});
            in_valid = 1'b1;
            ck  = b;
            ckp = bp;
            cyc = 0;
            while (1) begin
                @(negedge clk);
                if (in_ready || cyc > 200) break;
                cyc++;
            end
            check({name, "_in_ready"}, 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        if (nfeed == K) begin
`ifdef TURBO_ENC_TAIL_EN
            terminate(s1, t1);
            terminate(s2, t2);
            sb.push_back({t1[0], t1[1], t1[2], 1'b1, 1'b0});
            sb.push_back({t1[3], t1[4], t1[5], 1'b1, 1'b0});
            sb.push_back({t2[0], t2[1], t2[2], 1'b1, 1'b0});
            sb.push_back({t2[3], t2[4], t2[5], 1'b1, 1'b1});
`else
            t1 = '0;
            t2 = '0;
`endif
            cyc = 0;
            while ((sb.size() != 0 || busy) && cyc < 3000) begin
                @(negedge clk);
                cyc++;
            end
            check({name, "_busy_fall"}, 32'(busy), 32'd0);
            check({name, "_beat_count"}, 32'(beats_seen), 32'(K + TAILN));
        end
    endtask

    task automatic try_bad_len(input string name, input int L);
        @(posedge clk); #1;
        start  = 1'b1;
        length = 13'(L);
        @(posedge clk); #1;
        start  = 1'b0;
        check({name, "_len_err"}, 32'(len_err), 32'd1);
        check({name, "_busy"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({name, "_len_err_pulse"}, 32'(len_err), 32'd0);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; length = '0; in_valid = 1'b0;
        ck = 1'b0; ckp = 1'b0; out_ready = 1'b1; bp_mode = 1'b0;
        first_beat = '0; beats_seen = 0;
        #12;
        check("reset_outputs", 32'({out_valid, xk, zk, zkp, out_tail, out_last, busy, len_err, in_ready}), 32'd0);
        fork
            monitor();
            ready_driver();
        join_none
        @(posedge clk); #1;
        rst = 1'b0;

        // All-zero block
        for (int i = 0; i < 40; i++) begin ck_v[i] = 1'b0; ckp_v[i] = 1'b0; end
        run_block("zero", 40, 40);

        // Impulse on the natural input
        for (int i = 0; i < 40; i++) begin ck_v[i] = (i == 0); ckp_v[i] = 1'b0; end
        run_block("impulse", 40, 40);
        check("impulse_first_beat", 32'(first_beat), 32'b110);

        // Out-of-range lengths
        try_bad_len("len39", 39);
        try_bad_len("len6145", 6145);

        // Random block, first free-flowing then under backpressure
        for (int i = 0; i < 40; i++) begin
            ck_v[i]  = 1'($urandom_range(0, 1));
            ckp_v[i] = 1'($urandom_range(0, 1));
        end
        run_block("rand_free", 40, 40);
        bp_mode = 1'b1;
        run_block("rand_bp", 40, 40);
        bp_mode = 1'b0;

        // Asynchronous reset in the middle of a long block
        run_block("long", 6144, 20);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_outputs", 32'({out_valid, xk, zk, zkp, out_tail, out_last, busy, len_err, in_ready}), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        check("midrst_held", 32'({out_valid, busy}), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            ck_v[i]  = 1'($urandom_range(0, 1));
            ckp_v[i] = 1'($urandom_range(0, 1));
        end
        run_block("after_rst", 40, 40);

        // Back-to-back block with backpressure
        bp_mode = 1'b1;
        run_block("after_rst_bp", 40, 40);
        bp_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
